// File: rtl/prbs_chk_4tap.sv
// Purpose : self-synchronising serial checker for the 4-tap XNOR LFSR PRBS stream.
// Latency : LOCKED/ERR/ERR_CNT are registered; they reflect a sample one cycle after it is presented.
// Backpressure: none; EN qualifies each DIN sample and the checker never stalls its source.
//
// Ports:
//   CLK, RST      rising-edge clock, asynchronous active-high reset
//   EN, DIN       sample qualifier and serial PRBS bit from the generator
//   CLR_CNT       synchronous clear of ERR_CNT (wins over a same-cycle increment)
//   LOCKED        lock status
//   ERR           one-cycle pulse per mismatch counted while locked
//   ERR_CNT       saturating count of mismatches seen while locked
module prbs_chk_4tap #(
    parameter int N         = 8,
    parameter int FB_tap1   = 4,
    parameter int FB_tap2   = 5,
    parameter int FB_tap3   = 6,
    parameter int SYNC_GOOD = 16,
    parameter int WIN       = 64,
    parameter int BAD_MAX   = 8,
    parameter int CW        = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          DIN,
    input  logic          CLR_CNT,
    output logic          LOCKED,
    output logic          ERR,
    output logic [CW-1:0] ERR_CNT
);

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam int FW = $clog2(N + 1);
    localparam int GW = $clog2(SYNC_GOOD + 1);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int BW = $clog2(BAD_MAX + 1);

    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(SYNC_GOOD - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    logic [1:0]    state;
    logic [N:1]    hist;        // hist[k] = sample received k samples ago
    logic [FW-1:0] fill_cnt;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;

    logic lockup;
    logic pred;
    logic good;
    logic win_wrap;

    // All-ones is the XNOR lockup state; a real stream never shows it, so
    // a history of all ones marks the sample bad regardless of prediction.
    assign lockup   = &hist;
    assign pred     = ~(hist[N] ^ hist[FB_tap1] ^ hist[FB_tap2] ^ hist[FB_tap3]);
    assign good     = (DIN == pred) && !lockup;
    assign win_wrap = (win_cnt == WIN_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_FILL;
            hist     <= '0;
            fill_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            ERR_CNT  <= '0;
        end else begin
            ERR <= 1'b0;
            if (EN) begin
                hist <= {hist[N-1:1], DIN};
                case (state)
                    ST_FILL: begin
                        if (fill_cnt == FILL_LAST) begin
                            state    <= ST_SYNC;
                            good_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                    ST_SYNC: begin
                        if (good) begin
                            if (good_cnt == GOOD_LAST) begin
                                state   <= ST_LOCK;
                                LOCKED  <= 1'b1;
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCK: begin
                        win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                        if (!good) begin
                            ERR <= 1'b1;
                            // The current mismatch counts toward the drop.
                            if (bad_cnt == BAD_LAST) begin
                                state    <= ST_SYNC;
                                LOCKED   <= 1'b0;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                // Wrap clears after this sample's own evaluation.
                                bad_cnt <= win_wrap ? '0 : bad_cnt + 1'b1;
                            end
                        end else if (win_wrap) begin
                            bad_cnt <= '0;
                        end
                    end
                    default: state <= ST_FILL;
                endcase
            end

            if (CLR_CNT) begin
                ERR_CNT <= '0;
            end else if (EN && (state == ST_LOCK) && !good && (ERR_CNT != CNT_MAX)) begin
                ERR_CNT <= ERR_CNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_chk_4tap.sv
// Testbench for prbs_chk_4tap: a default instance and a CW=3 instance with a
// very large BAD_MAX share the same stimulus; both are compared every cycle
// against a sample-level behavioural model, plus directed spot checks.
module tb_prbs_chk_4tap;

    localparam int N      = 8;
    localparam int T1     = 4;
    localparam int T2     = 5;
    localparam int T3     = 6;
    localparam int SGOOD  = 16;
    localparam int WINL   = 64;
    localparam int BMAX_B = 1000;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        DIN;
    logic        CLR_CNT;
    logic        locked_a;
    logic        err_a;
    logic [15:0] cnt_a;
    logic        locked_b;
    logic        err_b;
    logic [2:0]  cnt_b;

    prbs_chk_4tap dut_a (
        .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN), .CLR_CNT(CLR_CNT),
        .LOCKED(locked_a), .ERR(err_a), .ERR_CNT(cnt_a)
    );

    prbs_chk_4tap #(.CW(3), .BAD_MAX(BMAX_B)) dut_b (
        .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN), .CLR_CNT(CLR_CNT),
        .LOCKED(locked_b), .ERR(err_b), .ERR_CNT(cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Behavioural checker model: phase 0 = filling, 1 = hunting, 2 = locked.
    typedef struct {
        int phase;
        int nfill;
        int good_run;
        int win_pos;
        int bad;
        int cnt;
        int err;
        int locked;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;
    bit   hq[$];      // every sample accepted since reset, oldest first
    bit   gq[$];      // generator state, last 8 outputs, newest at the back
    int   nsamp;
    bit   err_seen;
    bit   lock_seen;
    int   err_pulses;

    function automatic mdl_t step(mdl_t m, bit en, bit good, bit clr, int bad_max, int cnt_max);
        m.err = 0;
        if (en) begin
            case (m.phase)
                0: begin
                    m.nfill++;
                    if (m.nfill == N) begin
                        m.phase = 1;
                        m.good_run = 0;
                    end
                end
                1: begin
                    if (good) begin
                        m.good_run++;
                        if (m.good_run == SGOOD) begin
                            m.phase = 2;
                            m.locked = 1;
                            m.win_pos = 0;
                            m.bad = 0;
                        end
                    end else begin
                        m.good_run = 0;
                    end
                end
                default: begin
                    if (!good) begin
                        m.err = 1;
                        if (m.cnt < cnt_max) m.cnt++;
                        m.bad++;
                    end
                    m.win_pos++;
                    if (m.bad == bad_max) begin
                        m.phase = 1;
                        m.locked = 0;
                        m.good_run = 0;
                    end else if (m.win_pos == WINL) begin
                        m.win_pos = 0;
                        m.bad = 0;
                    end
                end
            endcase
        end
        if (clr) m.cnt = 0;
        return m;
    endfunction

    // Sample received k samples ago; before any sample the history is zero.
    function automatic bit hb(int k);
        return (hq.size() >= k) ? hq[hq.size() - k] : 1'b0;
    endfunction

    function automatic bit sample_good(bit d);
        bit ones = 1'b1;
        for (int k = 1; k <= N; k++) ones = ones & hb(k);
        return (d == ~(hb(N) ^ hb(T1) ^ hb(T2) ^ hb(T3))) && !ones;
    endfunction

    function automatic bit gen_peek();
        return ~(gq[8 - N] ^ gq[8 - T1] ^ gq[8 - T2] ^ gq[8 - T3]);
    endfunction

    function automatic bit gen_take();
        bit b;
        b = gen_peek();
        gq.push_back(b);
        void'(gq.pop_front());
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit en, input bit din, input bit clr);
        bit g;
        EN = en;
        DIN = din;
        CLR_CNT = clr;
        g = sample_good(din);
        @(posedge CLK);
        ma = step(ma, en, g, clr, 8, 65535);
        mb = step(mb, en, g, clr, BMAX_B, 7);
        if (en) begin
            hq.push_back(din);
            nsamp++;
        end
        #1;
        if (err_a === 1'b1) begin
            err_seen = 1'b1;
            err_pulses++;
        end
        if (locked_a === 1'b1) lock_seen = 1'b1;
        chk("a_locked", {31'd0, locked_a}, ma.locked);
        chk("a_err", {31'd0, err_a}, ma.err);
        chk("a_cnt", {16'd0, cnt_a}, ma.cnt);
        chk("b_locked", {31'd0, locked_b}, mb.locked);
        chk("b_err", {31'd0, err_b}, mb.err);
        chk("b_cnt", {29'd0, cnt_b}, mb.cnt);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        EN = 1'b0;
        CLR_CNT = 1'b0;
        RST = 1'b1;
        #1;
        chk("rst_locked", {31'd0, locked_a}, 0);
        chk("rst_err", {31'd0, err_a}, 0);
        chk("rst_cnt", {16'd0, cnt_a}, 0);
        chk("rst_cnt_b", {29'd0, cnt_b}, 0);
        ma = '{default: 0};
        mb = '{default: 0};
        hq.delete();
        nsamp = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Invert one generator bit that would have been 1, so the corrupted
    // history always contains a 0 and cannot alias the lockup pattern.
    task automatic flip_one(input bit clr);
        bit b;
        while (gen_peek() != 1'b1) cycle(1'b1, gen_take(), 1'b0);
        b = gen_take();
        cycle(1'b1, ~b, clr);
    endtask

    initial begin
        RST = 1'b0;
        EN = 1'b0;
        DIN = 1'b0;
        CLR_CNT = 1'b0;
        err_seen = 1'b0;
        lock_seen = 1'b0;
        err_pulses = 0;
        do begin
            gq.delete();
            for (int i = 0; i < 8; i++) gq.push_back(1'($urandom_range(0, 1)));
        end while (gq[0] & gq[1] & gq[2] & gq[3] & gq[4] & gq[5] & gq[6] & gq[7]);

        #2;
        do_reset();

        // Clean continuous stream: lock on the 24th sample, never an error.
        for (int i = 1; i <= 1000; i++) begin
            cycle(1'b1, gen_take(), 1'b0);
            if (i == 23) chk("lock_before_24", {31'd0, locked_a}, 0);
            if (i == 24) chk("lock_at_24", {31'd0, locked_a}, 1);
        end
        chk("clean_err_seen", {31'd0, err_seen}, 0);
        chk("clean_cnt", {16'd0, cnt_a}, 0);

        // Single inverted bit: five mismatches, lock held.
        err_pulses = 0;
        flip_one(1'b0);
        repeat (12) cycle(1'b1, gen_take(), 1'b0);
        chk("flip_pulses", err_pulses, 5);
        chk("flip_cnt", {16'd0, cnt_a}, 5);
        chk("flip_locked", {31'd0, locked_a}, 1);

        // Forced zeros starting on a window boundary: drop on 8th mismatch.
        repeat (70) cycle(1'b1, gen_take(), 1'b0);
        while (ma.win_pos != 0) cycle(1'b1, gen_take(), 1'b0);
        for (int i = 0; i < 20; i++) begin
            void'(gen_take());
            cycle(1'b1, 1'b0, 1'b0);
        end
        chk("zeros_unlock", {31'd0, locked_a}, 0);
        chk("zeros_cnt", {16'd0, cnt_a}, 13);
        repeat (24) cycle(1'b1, gen_take(), 1'b0);
        chk("relock", {31'd0, locked_a}, 1);
        chk("relock_cnt", {16'd0, cnt_a}, 13);

        // Clear on the mismatch cycle: count zero, pulse still present.
        repeat (70) cycle(1'b1, gen_take(), 1'b0);
        flip_one(1'b1);
        chk("clr_err", {31'd0, err_a}, 1);
        chk("clr_cnt", {16'd0, cnt_a}, 0);
        repeat (12) cycle(1'b1, gen_take(), 1'b0);
        chk("clr_after", {16'd0, cnt_a}, 4);

        // Narrow counter saturates at 7.
        flip_one(1'b0);
        repeat (12) cycle(1'b1, gen_take(), 1'b0);
        flip_one(1'b0);
        repeat (12) cycle(1'b1, gen_take(), 1'b0);
        chk("sat_b", {29'd0, cnt_b}, 7);

        // Constant ones from reset: never locks, never errors.
        do_reset();
        err_seen = 1'b0;
        lock_seen = 1'b0;
        repeat (500) cycle(1'b1, 1'b1, 1'b0);
        chk("ones_lock_seen", {31'd0, lock_seen}, 0);
        chk("ones_err_seen", {31'd0, err_seen}, 0);

        // EN one cycle in three, random DIN on idle cycles.
        do_reset();
        err_seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cycle(1'b1, gen_take(), 1'b0);
            if (i == 23) chk("en3_lock_before_24", {31'd0, locked_a}, 0);
            if (i == 24) chk("en3_lock_at_24", {31'd0, locked_a}, 1);
        end
        chk("en3_err_seen", {31'd0, err_seen}, 0);
        chk("en3_cnt", {16'd0, cnt_a}, 0);

        // Reset while locked with ERR high and a nonzero count.
        flip_one(1'b0);
        chk("pre_rst_err", {31'd0, err_a}, 1);
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, gen_take(), 1'b0);
            if (i == 23) chk("rerst_lock_before_24", {31'd0, locked_a}, 0);
            if (i == 24) chk("rerst_lock_at_24", {31'd0, locked_a}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
